coin_dispenser: RTL
===================

Name: coin_dispenser

Overview:
- Change/coin-eject controller; the output side of the coin-acceptor path.
- Takes a change amount in cents and drives two eject solenoids (10c and 5c) with timed pulses until the amount is paid out.
- Dispenses greedily: 10c coins first, then at most one 5c coin.
- Sits between the vending/accumulator logic (issues requests) and the board outputs (solenoid drivers, LEDs).

Parameters:
- PULSE_CYCLES, 4, eject pulse width in clk cycles (legal range >=1).
- GAP_CYCLES, 4, low time after every pulse in clk cycles (legal range >=1).
- AMT_W, 8, width of amount and counter signals.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  change amount in cents; sampled on accept.
- req_ready  out  1  high only in IDLE.
- eject10  out  1  10c solenoid drive.
- eject5  out  1  5c solenoid drive.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected.
- remaining  out  AMT_W  cents still owed on the current request.
- coins_out  out  AMT_W  running count of coins ejected since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, req_ready=1, eject10=0, eject5=0, done=0, err=0, remaining=0, coins_out=0.
- All outputs are registered (Moore). eject10 and eject5 are never high in the same cycle.
- Accept: a request is accepted on the rising edge where req_valid=1 and req_ready=1. req_amount is captured into remaining; the bus is ignored at all other times.
- Reject: if the accepted amount is not a multiple of 5:
  - err=1 for exactly the next cycle;
  - remaining is unchanged and the FSM stays in IDLE;
  - req_ready stays 1, so a new request is acceptable in the err cycle.
- Zero amount: go to DONE. done=1 in the next cycle, with no ejects.
- States:
  - IDLE: on a legal accept with amount>0, go to PULSE.
  - PULSE: drive eject10 if remaining>=10, else eject5. Hold the selected line for PULSE_CYCLES cycles. On the edge that ends the pulse, subtract the coin value (10 or 5) from remaining and add 1 to coins_out. Go to GAP.
  - GAP: both ejects low for GAP_CYCLES cycles. Then go to PULSE if remaining>0, else DONE.
  - DONE: done=1 and req_ready=0 for one cycle, then IDLE.
- Latency: accept edge at cycle T; first eject is high from T+1.
  - Each coin takes PULSE_CYCLES+GAP_CYCLES cycles.
  - For N coins, done is high at cycle T+1+N*(PULSE_CYCLES+GAP_CYCLES).
- Coin selection is fixed at PULSE entry and stays stable for the whole pulse.
- coins_out wraps modulo 2^AMT_W (255 -> 0 at the default width). remaining never underflows.
- req_valid held high through a transaction is ignored until the FSM returns to IDLE. It is then accepted again as a new request.
- Reset mid-pulse: ejects drop immediately (asynchronous), the request is abandoned, and the block returns to the reset values above.
- Timer: a single down-counter, wide enough for max(PULSE_CYCLES, GAP_CYCLES). It is reloaded on every PULSE or GAP entry.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, PULSE, GAP, DONE);
  - constants COIN_HI=10 and COIN_LO=5;
  - the amount width default.
- One sub-module: coin_pulse_timer. It is a loadable down-counter with load value, load strobe and an expired flag, used for both pulse and gap timing.
- The FSM and the arithmetic stay in coin_dispenser.

Test Plan:
- Reset then request 35 (defaults P=4, G=4) -> ejects 10,10,10,5. Each eject is high for 4 cycles with 4-cycle gaps. remaining reads 25,15,5,0. coins_out=4. done at T+33.
- Request 0 -> done at T+1, no ejects, req_ready back to 1 at T+2.
- Request 23 -> err=1 at T+1, no ejects, remaining unchanged. A request of 10 presented in the err cycle is accepted: one eject10, done at T+1+1+8.
- Assert rst_n=0 during the second pulse of a 20c request -> eject10 low in the same cycle, all outputs at reset values. A fresh request of 5 after release completes normally.
- Hold req_valid=1 with amount 5 continuously -> back-to-back transactions. Each consists of a single eject5 and a done pulse, with req_ready low between accept and done.
- Set coins_out near wrap (26 requests of 100) -> coins_out reaches 260 mod 256 = 4. eject10 and eject5 are never both high (checked by an assertion throughout).

Source files
------------

// File: rtl/coin_dispenser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coin_dispenser_pkg
//  Purpose  : Shared definitions for the coin dispenser: FSM state encoding,
//             coin denominations, default amount width and small helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package coin_dispenser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int COIN_HI       = 10;
    localparam int COIN_LO       = 5;
    localparam int AMT_W_DEFAULT = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Only amounts payable with 10c/5c coins are legal.
    function automatic logic is_mult5(input logic [31:0] v);
        return (v % 32'd5) == 32'd0;
    endfunction

endpackage : coin_dispenser_pkg
`default_nettype wire

// File: rtl/coin_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module   : coin_pulse_timer
//  Purpose  : Loadable down-counter used for both eject-pulse and gap timing.
//  Ports    : clk, rst_n      - clock / async active-low reset
//             load           - load strobe (load_val taken on this edge)
//             load_val       - number of cycles to time
//             expired        - high during the last timed cycle
//  Revision : 1.0 - initial release
// ============================================================================
module coin_pulse_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N gives N cycles; the N-th one sees count==1.
    assign expired = (count_q == WIDTH'(1));

endmodule : coin_pulse_timer
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : coin_dispenser
//  Purpose  : Change payout controller. Accepts a change amount and pays it
//             out greedily as timed 10c / 5c solenoid pulses.
//  Ports    : clk, rst_n  - clock / async active-low reset
//             req_valid   - change request present
//             req_amount  - amount in cents, sampled on accept
//             req_ready   - high only in IDLE
//             eject10     - 10c solenoid drive
//             eject5      - 5c solenoid drive
//             done        - one-cycle pulse on request completion
//             err         - one-cycle pulse on rejected (non-multiple-of-5) request
//             remaining   - cents still owed
//             coins_out   - coins ejected since reset (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module coin_dispenser
    import coin_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int AMT_W        = AMT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             eject10,
    output logic             eject5,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coins_out
);

    localparam int TMR_MAX = max_int(PULSE_CYCLES, GAP_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] C_PULSE_LOAD = TMR_W'(PULSE_CYCLES);
    localparam logic [TMR_W-1:0] C_GAP_LOAD   = TMR_W'(GAP_CYCLES);
    localparam logic [AMT_W-1:0] C_COIN_HI    = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0] C_COIN_LO    = AMT_W'(COIN_LO);

    state_t           state_q,     state_d;
    logic             req_ready_q, req_ready_d;
    logic             eject10_q,   eject10_d;
    logic             eject5_q,    eject5_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] coins_out_q, coins_out_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;
    logic [AMT_W-1:0] coin_val;

    coin_pulse_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Value of the coin currently being ejected; the selection is latched in
    // the eject flops at PULSE entry so it cannot change mid-pulse.
    assign coin_val = eject10_q ? C_COIN_HI : C_COIN_LO;

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        eject10_d   = 1'b0;
        eject5_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        remaining_d = remaining_q;
        coins_out_d = coins_out_q;
        tmr_load    = 1'b0;
        tmr_val     = C_PULSE_LOAD;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    if (!is_mult5(32'(req_amount))) begin
                        // Rejected: stay ready so a retry can land in the err cycle.
                        err_d = 1'b1;
                    end else if (req_amount == '0) begin
                        state_d     = ST_DONE;
                        req_ready_d = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = req_amount;
                    end else begin
                        state_d     = ST_PULSE;
                        req_ready_d = 1'b0;
                        remaining_d = req_amount;
                        tmr_load    = 1'b1;
                        tmr_val     = C_PULSE_LOAD;
                        eject10_d   = (req_amount >= C_COIN_HI);
                        eject5_d    = (req_amount <  C_COIN_HI);
                    end
                end
            end

            ST_PULSE: begin
                eject10_d = eject10_q;
                eject5_d  = eject5_q;
                if (tmr_expired) begin
                    state_d     = ST_GAP;
                    eject10_d   = 1'b0;
                    eject5_d    = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = C_GAP_LOAD;
                    remaining_d = (remaining_q >= coin_val) ? (remaining_q - coin_val) : '0;
                    coins_out_d = coins_out_q + AMT_W'(1);
                end
            end

            ST_GAP: begin
                if (tmr_expired) begin
                    if (remaining_q != '0) begin
                        state_d   = ST_PULSE;
                        tmr_load  = 1'b1;
                        tmr_val   = C_PULSE_LOAD;
                        eject10_d = (remaining_q >= C_COIN_HI);
                        eject5_d  = (remaining_q <  C_COIN_HI);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            eject10_q   <= 1'b0;
            eject5_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            remaining_q <= '0;
            coins_out_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            eject10_q   <= eject10_d;
            eject5_q    <= eject5_d;
            done_q      <= done_d;
            err_q       <= err_d;
            remaining_q <= remaining_d;
            coins_out_q <= coins_out_d;
        end
    end

    assign req_ready = req_ready_q;
    assign eject10   = eject10_q;
    assign eject5    = eject5_q;
    assign done      = done_q;
    assign err       = err_q;
    assign remaining = remaining_q;
    assign coins_out = coins_out_q;

endmodule : coin_dispenser
`default_nettype wire
